// File: rtl/jtag_dtm_pkg.sv
// rtl/jtag_dtm_pkg.sv - IR codes, DTMCS field offsets, DMI op and FSM state types
package jtag_dtm_pkg;

    localparam logic [4:0] IR_IDCODE = 5'h01;
    localparam logic [4:0] IR_DTMCS  = 5'h10;
    localparam logic [4:0] IR_DMI    = 5'h11;

    localparam int DTMCS_VERSION_LSB   = 0;
    localparam int DTMCS_ABITS_LSB     = 4;
    localparam int DTMCS_DMISTAT_LSB   = 10;
    localparam int DTMCS_IDLE_LSB      = 12;
    localparam int DTMCS_DMIRESET_BIT  = 16;
    localparam int DTMCS_HARDRESET_BIT = 17;

    localparam logic [3:0] DTMCS_VERSION = 4'd1;

    // BUSY shares encoding 3 with the reserved request op; FAILED shares 2 with WRITE
    typedef enum logic [1:0] {
        DMI_NOP   = 2'd0,
        DMI_READ  = 2'd1,
        DMI_WRITE = 2'd2,
        DMI_BUSY  = 2'd3
    } dmi_op_e;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_REQ       = 2'd1,
        ST_WAIT_RESP = 2'd2
    } dmi_state_e;

    typedef enum logic [1:0] {
        DR_BYPASS = 2'd0,
        DR_IDCODE = 2'd1,
        DR_DTMCS  = 2'd2,
        DR_DMI    = 2'd3
    } dr_sel_e;

    function automatic dr_sel_e decode_ir(input logic [4:0] ir);
        case (ir)
            IR_IDCODE: return DR_IDCODE;
            IR_DTMCS:  return DR_DTMCS;
            IR_DMI:    return DR_DMI;
            default:   return DR_BYPASS;
        endcase
    endfunction

endpackage

// File: rtl/jtag_dtm_dr_if.sv
// rtl/jtag_dtm_dr_if.sv - DMI request/response handshake bundle between DTM and debug module
interface jtag_dtm_dr_if #(
    parameter int ABITS = 7
) ();
    logic             dmi_req_valid_o;
    logic             dmi_req_ready_i;
    logic [ABITS-1:0] dmi_req_addr_o;
    logic [1:0]       dmi_req_op_o;
    logic [31:0]      dmi_req_data_o;
    logic             dmi_resp_valid_i;
    logic             dmi_resp_ready_o;
    logic [31:0]      dmi_resp_data_i;
    logic [1:0]       dmi_resp_op_i;

    modport master (
        output dmi_req_valid_o, dmi_req_addr_o, dmi_req_op_o, dmi_req_data_o, dmi_resp_ready_o,
        input  dmi_req_ready_i, dmi_resp_valid_i, dmi_resp_data_i, dmi_resp_op_i
    );

    modport slave (
        input  dmi_req_valid_o, dmi_req_addr_o, dmi_req_op_o, dmi_req_data_o, dmi_resp_ready_o,
        output dmi_req_ready_i, dmi_resp_valid_i, dmi_resp_data_i, dmi_resp_op_i
    );
endinterface

// File: rtl/jtag_dtm_dmi_fsm.sv
// rtl/jtag_dtm_dmi_fsm.sv - DMI request/response FSM and sticky error; JTAG_DTM_DMI_TIMEOUT_EN adds a response timeout
module jtag_dtm_dmi_fsm
    import jtag_dtm_pkg::*;
#(
    parameter int ABITS          = 7,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             tck_i,
    input  logic             trst_ni,
    input  logic             i_update_dmi,
    input  logic             i_capture_dmi,
    input  logic             i_dmireset,
    input  logic             i_dmihardreset,
    input  logic [ABITS-1:0] i_addr,
    input  logic [31:0]      i_data,
    input  logic [1:0]       i_op,
    output logic [ABITS-1:0] o_last_addr,
    output logic [31:0]      o_resp_data,
    output logic [1:0]       o_sticky,
    jtag_dtm_dr_if.master    dmi
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("jtag_dtm_dmi_fsm: TIMEOUT_CYCLES must be positive");
    end

    dmi_state_e       r_state, w_state_next;
    logic [ABITS-1:0] r_addr;
    logic [31:0]      r_data;
    logic [1:0]       r_op;
    logic [31:0]      r_resp_data;
    logic [1:0]       r_sticky, w_sticky_base, w_sticky_next;
    logic             w_start, w_busy_hit, w_resp_take, w_err_set, w_timeout;

`ifdef JTAG_DTM_DMI_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_timer;

    // Count TCK cycles spent waiting for a response; restart whenever we leave WAIT_RESP
    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni)                   r_timer <= '0;
        else if (r_state != ST_WAIT_RESP) r_timer <= '0;
        else                            r_timer <= r_timer + 1'b1;
    end

    assign w_timeout = (r_state == ST_WAIT_RESP) && (r_timer == TW'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) r_state <= ST_IDLE;
        else          r_state <= w_state_next;
    end

    // Next state and transaction events; a hard reset abandons any outstanding response
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_busy_hit   = 1'b0;
        w_resp_take  = 1'b0;
        w_err_set    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_update_dmi && (r_sticky == 2'd0) &&
                    ((i_op == DMI_READ) || (i_op == DMI_WRITE))) begin
                    w_start      = 1'b1;
                    w_state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                w_busy_hit = i_update_dmi || i_capture_dmi;
                if (dmi.dmi_req_ready_i) w_state_next = ST_WAIT_RESP;
            end
            ST_WAIT_RESP: begin
                w_busy_hit = i_update_dmi || i_capture_dmi;
                if (dmi.dmi_resp_valid_i) begin
                    w_resp_take  = 1'b1;
                    w_err_set    = (dmi.dmi_resp_op_i == 2'd2);
                    w_state_next = ST_IDLE;
                end else if (w_timeout) begin
                    w_err_set    = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
        if (i_dmihardreset) begin
            w_state_next = ST_IDLE;
            w_start      = 1'b0;
            w_resp_take  = 1'b0;
            w_err_set    = 1'b0;
        end
    end

    // Sticky error: clears first, then busy (3) beats failed (2)
    always_comb begin
        w_sticky_base = (i_dmireset || i_dmihardreset) ? 2'd0 : r_sticky;
        w_sticky_next = w_sticky_base;
        if (w_busy_hit)                              w_sticky_next = 2'd3;
        else if (w_err_set && w_sticky_base != 2'd3) w_sticky_next = 2'd2;
    end

    // Sticky error register
    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) r_sticky <= 2'd0;
        else          r_sticky <= w_sticky_next;
    end

    // Request fields latch on an accepted update and stay stable until the next one
    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            r_addr <= '0;
            r_data <= '0;
            r_op   <= 2'd0;
        end else if (w_start) begin
            r_addr <= i_addr;
            r_data <= i_data;
            r_op   <= i_op;
        end
    end

    // Response data captured on the response handshake
    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni)         r_resp_data <= '0;
        else if (w_resp_take) r_resp_data <= dmi.dmi_resp_data_i;
    end

    assign dmi.dmi_req_valid_o  = (r_state == ST_REQ);
    assign dmi.dmi_resp_ready_o = (r_state == ST_WAIT_RESP);
    assign dmi.dmi_req_addr_o   = r_addr;
    assign dmi.dmi_req_data_o   = r_data;
    assign dmi.dmi_req_op_o     = r_op;

    assign o_last_addr = r_addr;
    assign o_resp_data = r_resp_data;
    assign o_sticky    = r_sticky;

endmodule

// File: rtl/jtag_dtm_dr.sv
// rtl/jtag_dtm_dr.sv - JTAG DTM data registers (IDCODE/DTMCS/DMI/BYPASS); JTAG_DTM_DMI_TIMEOUT_EN enables DMI response timeout
module jtag_dtm_dr
    import jtag_dtm_pkg::*;
#(
    parameter logic [31:0] IDCODE_VALUE   = 32'h1000_0DB3,
    parameter int          ABITS          = 7,
    parameter logic [2:0]  IDLE_HINT      = 3'd1,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic          tck_i,
    input  logic          trst_ni,
    input  logic          tdi_i,
    input  logic [4:0]    ir_i,
    input  logic          capture_dr_i,
    input  logic          shift_dr_i,
    input  logic          update_dr_i,
    output logic          tdo_o,
    jtag_dtm_dr_if.master dmi
);

    localparam int DRW = ABITS + 34;

    if (IDCODE_VALUE[0] != 1'b1) begin : g_bad_idcode
        $error("jtag_dtm_dr: IDCODE_VALUE bit 0 must be 1");
    end

    dr_sel_e          w_sel;
    logic             w_update, w_capture, w_shift;
    logic [DRW-1:0]   r_shift, w_shift_next, w_capture_val;
    logic [ABITS-1:0] w_last_addr;
    logic [31:0]      w_resp_data;
    logic [1:0]       w_sticky, w_dmi_op;

    assign w_sel     = decode_ir(ir_i);
    assign w_update  = update_dr_i;
    assign w_capture = capture_dr_i && !update_dr_i;
    assign w_shift   = shift_dr_i && !capture_dr_i && !update_dr_i;

    // Only busy and failed are ever stored, but map explicitly so stray codes read as ok
    assign w_dmi_op = (w_sticky == 2'd3) ? 2'd3 : (w_sticky == 2'd2) ? 2'd2 : 2'd0;

    // Value loaded into the shift register on capture, selected by IR
    always_comb begin
        w_capture_val = '0;
        case (w_sel)
            DR_IDCODE: w_capture_val[31:0] = IDCODE_VALUE;
            DR_DTMCS: begin
                w_capture_val[DTMCS_VERSION_LSB +: 4] = DTMCS_VERSION;
                w_capture_val[DTMCS_ABITS_LSB   +: 6] = 6'(ABITS);
                w_capture_val[DTMCS_DMISTAT_LSB +: 2] = w_sticky;
                w_capture_val[DTMCS_IDLE_LSB    +: 3] = IDLE_HINT;
            end
            DR_DMI:  w_capture_val = {w_last_addr, w_resp_data, w_dmi_op};
            default: w_capture_val = '0;
        endcase
    end

    // Shift right one place, inserting TDI at the top of the active register width
    always_comb begin
        w_shift_next = {1'b0, r_shift[DRW-1:1]};
        case (w_sel)
            DR_IDCODE, DR_DTMCS: w_shift_next[31]    = tdi_i;
            DR_DMI:              w_shift_next[DRW-1] = tdi_i;
            default:             w_shift_next[0]     = tdi_i;
        endcase
    end

    // Shared shift register; update has priority, then capture, then shift
    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni)       r_shift <= '0;
        else if (w_update)  r_shift <= r_shift;
        else if (w_capture) r_shift <= w_capture_val;
        else if (w_shift)   r_shift <= w_shift_next;
    end

    assign tdo_o = r_shift[0];

    jtag_dtm_dmi_fsm #(
        .ABITS          (ABITS),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_dmi_fsm (
        .tck_i          (tck_i),
        .trst_ni        (trst_ni),
        .i_update_dmi   (w_update && (w_sel == DR_DMI)),
        .i_capture_dmi  (w_capture && (w_sel == DR_DMI)),
        .i_dmireset     (w_update && (w_sel == DR_DTMCS) && r_shift[DTMCS_DMIRESET_BIT]),
        .i_dmihardreset (w_update && (w_sel == DR_DTMCS) && r_shift[DTMCS_HARDRESET_BIT]),
        .i_addr         (r_shift[DRW-1:34]),
        .i_data         (r_shift[33:2]),
        .i_op           (r_shift[1:0]),
        .o_last_addr    (w_last_addr),
        .o_resp_data    (w_resp_data),
        .o_sticky       (w_sticky),
        .dmi            (dmi)
    );

endmodule

// File: doc/jtag_dtm_dr.md
Name: jtag_dtm_dr

Overview:
- Data-register stage directly downstream of the JTAG TAP controller, in the TCK domain.
- Decodes the latched 5-bit IR and owns the IDCODE, DTMCS, DMI and BYPASS data registers.
- Shifts TDI to TDO on the TAP's capture/shift/update strobes.
- Converts DMI updates into a valid/ready request to the debug module and collects the response.

Parameters:
- IDCODE_VALUE, 32'h1000_0DB3, value captured into IDCODE. Bit 0 must be 1.
- ABITS, 7, DMI address width. DMI DR width is ABITS+34.
- IDLE_HINT, 3'd1, value reported in DTMCS.idle.
- TIMEOUT_CYCLES, 1024, TCK cycles allowed in WAIT_RESP. Used only with the optional feature.

Ports:
- tck_i, input, 1, JTAG test clock.
- trst_ni, input, 1, reset, asynchronous, active-low.
- tdi_i, input, 1, serial data in.
- ir_i, input, 5, current instruction from the TAP.
- capture_dr_i, input, 1, TAP is in CAPTURE_DR.
- shift_dr_i, input, 1, TAP is in SHIFT_DR.
- update_dr_i, input, 1, TAP is in UPDATE_DR.
- tdo_o, output, 1, serial data out.
- dmi_req_valid_o, output, 1, DMI request valid.
- dmi_req_ready_i, input, 1, debug module accepts the request.
- dmi_req_addr_o, output, ABITS, request address.
- dmi_req_op_o, output, 2, request op: 1=read, 2=write.
- dmi_req_data_o, output, 32, write data.
- dmi_resp_valid_i, input, 1, response valid.
- dmi_resp_ready_o, output, 1, DTM ready for the response.
- dmi_resp_data_i, input, 32, response data.
- dmi_resp_op_i, input, 2, response status: 0=ok, 2=failed.

Behaviour:
- IR decode:
  - 0x01 selects IDCODE (32 bits).
  - 0x10 selects DTMCS (32 bits).
  - 0x11 selects DMI (ABITS+34 bits).
  - All other codes select BYPASS (1 bit).
- Shift register:
  - One register of width ABITS+34; the active width follows the IR.
  - Capture loads the selected register's content.
  - Each shift cycle moves the register right one bit and inserts tdi_i at bit (active width - 1).
  - tdo_o = shift register bit 0, combinational; pad-level negedge retiming belongs to the pad ring.
- Capture contents:
  - IDCODE: IDCODE_VALUE.
  - BYPASS: 0.
  - DTMCS: version=1 [3:0], abits [9:4], dmistat [11:10], IDLE_HINT [14:12]; all other bits 0.
  - DMI: {last_addr, resp_data, op}. op=3 if the sticky error is 3, op=2 if the sticky error is 2, otherwise 0.
- Update, DTMCS:
  - bit 16 (dmireset) clears the sticky error.
  - bit 17 (dmihardreset) clears the sticky error and forces the FSM to IDLE. If a request was already accepted, the outstanding response is discarded.
- Update, DMI:
  - Starts a request only if op is 1 or 2, the FSM is IDLE and the sticky error is 0.
  - Update while the FSM is not IDLE sets the sticky error to 3 (busy) and is otherwise ignored.
  - Capture of DMI while the FSM is not IDLE also sets the sticky error to 3.
  - op 0 or 3 does nothing.
- FSM states IDLE, REQ, WAIT_RESP:
  - IDLE -> REQ on an accepted update. Latches addr, data and op into output registers the same cycle.
  - REQ: dmi_req_valid_o=1 and held stable until dmi_req_ready_i; then WAIT_RESP.
  - WAIT_RESP: dmi_resp_ready_o=1. On dmi_resp_valid_i, resp_data <= dmi_resp_data_i. If dmi_resp_op_i=2, sticky <= 2 unless sticky is already 3. Then IDLE.
- Sticky error: 2 bits. 3 takes precedence over 2. Cleared only by dmireset, dmihardreset or reset. dmistat reports the sticky value.
- Reset (any state, including mid-transaction):
  - FSM to IDLE.
  - tdo_o, dmi_req_valid_o, dmi_resp_ready_o, request fields, resp_data, last_addr, sticky and shift register all 0.
- Simultaneous strobes: capture, shift and update are mutually exclusive from the TAP. If more than one is asserted, priority is update > capture > shift.

Optional Feature:
- Macro: JTAG_DTM_DMI_TIMEOUT_EN.
- Defined: a counter runs in WAIT_RESP. When it reaches TIMEOUT_CYCLES, the FSM returns to IDLE, sticky <= 2 and any later response is dropped (dmi_resp_ready_o=0).
- Undefined: no counter; WAIT_RESP waits indefinitely.

Decomposition:
- Package jtag_dtm_pkg holds:
  - IR code constants.
  - DTMCS field offsets.
  - DMI op enum (NOP, READ, WRITE, RSVD/BUSY).
  - FSM state enum.
- Sub-module jtag_dtm_dmi_fsm contains the request/response FSM and the optional timeout.

Test Plan:
- IR=0x01, capture, shift 32 -> tdo_o serialises 0x10000DB3 LSB first.
- IR=0x1F, shift tdi pattern 1,0,1,1 -> tdo_o shows 0 (capture value), then 1,0,1, delayed one cycle.
- IR=0x11, shift addr=0x10, data=0xDEADBEEF, op=2, update -> valid held 3 cycles under ready=0, then accepted with exact fields. Response op=0, data=0x5 -> next DMI capture reads data=5, op=0.
- Second DMI update while in WAIT_RESP -> no new request. Next capture op=3. DTMCS write bit16 -> dmistat=0.
- Response op=2 -> dmistat=2 and new updates are blocked until dmireset.
- trst_ni low during REQ -> valid drops immediately, all outputs 0. With timeout macro and no response -> IDLE after 1024 cycles, dmistat=2.
